led_blink_scheduler: RTL

Round-robin scheduler that shares a single status LED between several requesters. Each requester asks to play a blink code: a number of on/off pulses followed by a dark gap. The block grants one requester at a time, latches its code, and drives the LED output through the full sequence before it arbitrates again. It sits between the lab's status sources and the LED pin, replacing a free-running blinker on that output.

---
 rtl/led_blink_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler
//   Round-robin scheduler that shares one status LED between N_REQ
//   requesters. The winner's blink code k is latched at grant time, then the
//   LED plays k on/off pulses (LED_TMR cycles per phase) followed by a dark
//   gap of GAP_TMR cycles. Only after that does the block arbitrate again.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   reset  : asynchronous, active-low reset
//   req    : [N_REQ] level request per requester
//   code   : [N_REQ*CNT_W] blink count for requester i at [i*CNT_W +: CNT_W]
//   out    : registered LED drive
//   grant  : [N_REQ] one-hot requester being served, zero when idle
//   busy   : high while a sequence is in progress (grant != 0)
//   done   : one-cycle pulse on the first idle cycle after a sequence
module led_blink_scheduler #(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 3,
  parameter int LED_TMR = 10,
  parameter int GAP_TMR = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] code,
  output logic                   out,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   done
);

  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMAX = (LED_TMR > GAP_TMR) ? LED_TMR : GAP_TMR;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  // Timer counts down to zero, so a phase of L cycles loads L-1.
  localparam logic [TW-1:0] LED_LD = TW'(LED_TMR - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_TMR - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic               out_q, out_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Arbitration: search from ptr+1 upward, wrapping, first set bit wins.
  logic               win_vld;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      cand;
  logic [N_REQ-1:0]   win_oh;
  logic [CNT_W-1:0]   win_code;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % N_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
    win_code        = code[win_idx*CNT_W +: CNT_W];
  end

  wire tmr_zero = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    k_d     = k_q;
    tmr_d   = tmr_q;
    out_d   = out_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d = win_oh;
          ptr_d   = win_idx;
          busy_d  = 1'b1;
          k_d     = win_code;
          if (win_code != '0) begin
            state_d = S_ON;
            out_d   = 1'b1;
            tmr_d   = LED_LD;
          end else begin
            // A zero code still owns the LED for one dark gap.
            state_d = S_GAP;
            out_d   = 1'b0;
            tmr_d   = GAP_LD;
          end
        end
      end
      S_ON: begin
        if (tmr_zero) begin
          state_d = S_OFF;
          out_d   = 1'b0;
          tmr_d   = LED_LD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_OFF: begin
        if (tmr_zero) begin
          k_d = k_q - CNT_W'(1);
          if (k_q != CNT_W'(1)) begin
            state_d = S_ON;
            out_d   = 1'b1;
            tmr_d   = LED_LD;
          end else begin
            state_d = S_GAP;
            tmr_d   = GAP_LD;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_GAP: begin
        if (tmr_zero) begin
          state_d = S_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(N_REQ - 1);  // requester 0 first after reset
      k_q     <= '0;
      tmr_q   <= '0;
      out_q   <= 1'b0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      k_q     <= k_d;
      tmr_q   <= tmr_d;
      out_q   <= out_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out   = out_q;
  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
